// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: S-memory geometry, KSA shuffle state encoding and key byte lookup.
package rc4_pkg;

    localparam int unsigned S_DEPTH = 256;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 8;

    typedef enum logic [3:0] {
        StIdle,
        StRdSi,
        StWaitSi,
        StCapSi,
        StRdSj,
        StWaitSj,
        StCapSj,
        StWrSi,
        StWrSj,
        StDone
    } ksa_state_t;

    // Byte 0 is the most significant byte of an n_bytes-wide key right-aligned in 64 bits.
    function automatic logic [DATA_W-1:0] key_byte(input logic [63:0]   key,
                                                   input int unsigned   n_bytes,
                                                   input logic [2:0]    idx);
        logic [63:0] shifted;
        shifted = key >> (8 * (n_bytes - 1 - 32'(idx)));
        return shifted[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/counter_en.sv
// Free-running up counter with synchronous clear and increment enable.
module counter_en #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_en_i) begin
            count_q <= count_q + Width'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ksa_shuffle_fsm.sv
// RC4 key-scheduling shuffle: for i = 0..255, j += S[i] + key[i mod KEY_BYTES], swap S[i], S[j].
module ksa_shuffle_fsm
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_BYTES  = 3,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic [ADDR_W-1:0]      address,
    output logic [DATA_W-1:0]      data,
    output logic                   wren,
    input  logic [DATA_W-1:0]      q,
    output logic                   busy,
    output logic                   fin_strobe
);

    ksa_state_t             state_q;
    logic                   start_q;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [ADDR_W-1:0]      i_q;
    logic [ADDR_W-1:0]      j_q;
    logic [2:0]             key_idx_q;
    logic [DATA_W-1:0]      si_q;
    logic [DATA_W-1:0]      sj_q;

    logic                   launch;
    logic                   i_inc;
    logic [DATA_W-1:0]      key_b;
    logic [ADDR_W-1:0]      j_sum;

    counter_en #(
        .Width    (ADDR_W)
    ) u_i_cnt (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (launch),
        .inc_en_i (i_inc),
        .count_o  (i_q)
    );

    always_comb begin
        launch = (state_q == StIdle) && start && !start_q;
        i_inc  = (state_q == StWrSj);
        key_b  = key_byte(64'(key_q), KEY_BYTES, key_idx_q);
        j_sum  = j_q + q + key_b;
    end

    // Outputs are registered, so each branch sets the values seen in the state it enters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            key_q      <= '0;
            j_q        <= '0;
            key_idx_q  <= '0;
            si_q       <= '0;
            sj_q       <= '0;
            address    <= '0;
            data       <= '0;
            wren       <= 1'b0;
            busy       <= 1'b0;
            fin_strobe <= 1'b0;
        end else begin
            start_q    <= start;
            data       <= '0;
            wren       <= 1'b0;
            fin_strobe <= 1'b0;
            case (state_q)
                StIdle: begin
                    address <= '0;
                    if (launch) begin
                        key_q     <= secret_key;
                        j_q       <= '0;
                        key_idx_q <= '0;
                        busy      <= 1'b1;
                        state_q   <= StRdSi;
                    end
                end
                StRdSi:   state_q <= (RD_LATENCY == 2) ? StWaitSi : StCapSi;
                StWaitSi: state_q <= StCapSi;
                StCapSi: begin
                    si_q    <= q;
                    j_q     <= j_sum;
                    address <= j_sum;
                    state_q <= StRdSj;
                end
                StRdSj:   state_q <= (RD_LATENCY == 2) ? StWaitSj : StCapSj;
                StWaitSj: state_q <= StCapSj;
                StCapSj: begin
                    sj_q    <= q;
                    address <= i_q;
                    data    <= q;
                    wren    <= 1'b1;
                    state_q <= StWrSi;
                end
                StWrSi: begin
                    address <= j_q;
                    data    <= si_q;
                    wren    <= 1'b1;
                    state_q <= StWrSj;
                end
                StWrSj: begin
                    key_idx_q <= (key_idx_q == 3'(KEY_BYTES - 1)) ? 3'd0 : key_idx_q + 3'd1;
                    if (i_q == ADDR_W'(S_DEPTH - 1)) begin
                        address    <= '0;
                        busy       <= 1'b0;
                        fin_strobe <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        address <= i_q + ADDR_W'(1);
                        state_q <= StRdSi;
                    end
                end
                StDone: begin
                    address <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    address <= '0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
